// File: rtl/flag_unit.sv
// flag_unit: architectural flag register, conditional jump resolution and flag save stack
module flag_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   alu_csr,
  input  logic                         flag_we,
  input  logic                         flag_save,
  input  logic                         flag_restore,
  input  logic                         br_valid,
  output logic                         br_ready,
  input  logic [2:0]                   br_cond,
  input  logic [AW-1:0]                br_target,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_take,
  output logic [AW-1:0]                res_target,
  output logic [3:0]                   flags,
  output logic [$clog2(DEPTH+1)-1:0]   stk_depth,
  output logic                         stk_err
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [3:0]    r_flags;
  logic [3:0]    r_stk [DEPTH];
  logic [DW-1:0] r_depth;
  logic          r_err;
  logic          r_res_valid;
  logic          r_res_take;
  logic [AW-1:0] r_res_target;
  logic          w_full;
  logic          w_empty;
  logic          w_pop_only;
  logic          w_push_only;
  logic          w_accept;
  logic          w_take;
  logic [3:0]    w_top;
  logic [3:0]    w_f;
  logic [7:0]    w_conds;
  assign w_full      = r_depth == DW'(DEPTH);
  assign w_empty     = r_depth == '0;
  assign w_pop_only  = flag_restore & !flag_save;
  assign w_push_only = flag_save & !flag_restore;
  assign w_top       = r_stk[IW'(r_depth - 1'b1)];
  // flag layout is {sign, zero, carry, overflow}; same-cycle ALU flags are forwarded
  assign w_f         = flag_we ? alu_csr : r_flags;
  assign w_conds     = {w_f[0], w_f[3] ^ w_f[0], w_f[3], !w_f[1], w_f[1], !w_f[2], w_f[2], 1'b1};
  assign w_take      = w_conds[br_cond];
  assign br_ready    = !(r_res_valid & !res_ready) & !flag_restore;
  assign w_accept    = br_valid & br_ready;
  assign res_valid   = r_res_valid;
  assign res_take    = r_res_take;
  assign res_target  = r_res_target;
  assign flags       = r_flags;
  assign stk_depth   = r_depth;
  assign stk_err     = r_err;
  // flag register, stack pointer and sticky error; restore outranks flag_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop_only) begin
        if (!w_empty) begin
          r_flags <= w_top;
          r_depth <= r_depth - 1'b1;
        end else r_err <= 1'b1;
      end else if (flag_we) r_flags <= alu_csr;
      if (w_push_only) begin
        if (!w_full) r_depth <= r_depth + 1'b1;
        else r_err <= 1'b1;
      end
    end
  end
  // stack storage; entries above the pointer are never read so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push_only && !w_full) r_stk[IW'(r_depth)] <= r_flags;
  end
  // registered jump decision with valid/ready hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid  <= 1'b0;
      r_res_take   <= 1'b0;
      r_res_target <= '0;
    end else if (w_accept) begin
      r_res_valid  <= 1'b1;
      r_res_take   <= w_take;
      r_res_target <= br_target;
    end else if (res_ready) r_res_valid <= 1'b0;
  end
endmodule
